// File: rtl/rr_bus_arbiter.sv
// N-master round-robin bus arbiter: a granted master holds the bus while it keeps
// its request, up to MAX_HOLD cycles under contention, with one idle cycle between grants.
module rr_bus_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 expire
);

    localparam int ID_W  = $clog2(N);
    localparam int CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N - 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_e;

    state_e              state_q, state_d;
    logic [N-1:0]        grant_q, grant_d;
    logic                grant_valid_q, grant_valid_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic                expire_q, expire_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [ID_W-1:0]     winner;
    logic                found;
    logic [ID_W-1:0]     idx;
    logic                others_waiting;

    // Rotating search: the master just after the last owner has highest priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = ID_W'((int'(last_q) + k) % N);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign others_waiting = |(req & ~grant_q);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        expire_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    grant_id_d      = winner;
                    last_d          = winner;
                    cnt_d           = '0;
                    state_d         = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!req[last_q]) begin
                    grant_d    = '0;
                    grant_id_d = '0;
                    cnt_d      = '0;
                    state_d    = S_IDLE;
                end else if (cnt_q == CNT_MAX && others_waiting) begin
                    grant_d    = '0;
                    grant_id_d = '0;
                    cnt_d      = '0;
                    expire_d   = 1'b1;
                    state_d    = S_IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                grant_d    = '0;
                grant_id_d = '0;
                state_d    = S_IDLE;
            end
        endcase

        grant_valid_d = |grant_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            expire_q      <= 1'b0;
            last_q        <= LAST_RST;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            expire_q      <= expire_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign expire      = expire_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter (N=4, MAX_HOLD=4): a bus-ownership model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_rr_bus_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic         expire;

    int errors = 0;
    int checks = 0;

    rr_bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .expire     (expire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus-ownership model: who owns the bus, for how many cycles so far, who owned it last.
    logic       m_busy;
    logic [1:0] m_owner;
    logic [1:0] m_last;
    int         m_held;
    logic       m_exp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_owner <= 2'd0;
            m_last  <= 2'd3;
            m_held  <= 0;
            m_exp   <= 1'b0;
        end else if (!m_busy) begin
            m_exp <= 1'b0;
            if (req != '0) begin
                logic [1:0] w;
                logic       got;
                logic [1:0] cand;
                w   = 2'd0;
                got = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    cand = m_last + 2'(k);
                    if (!got && req[cand]) begin
                        got = 1'b1;
                        w   = cand;
                    end
                end
                m_busy  <= 1'b1;
                m_owner <= w;
                m_last  <= w;
                m_held  <= 1;
            end
        end else if (!req[m_owner]) begin
            m_busy <= 1'b0;
            m_exp  <= 1'b0;
        end else if (m_held >= MAX_HOLD && (req & ~(4'b0001 << m_owner)) != '0) begin
            m_busy <= 1'b0;
            m_exp  <= 1'b1;
        end else begin
            m_held <= m_held + 1;
            m_exp  <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("grant", grant, m_busy ? (4'b0001 << m_owner) : 4'b0000);
        check("grant_valid", grant_valid, m_busy);
        check("grant_id", grant_id, m_busy ? m_owner : 2'd0);
        check("expire", expire, m_exp);
        check("onehot", ($countones(grant) <= 1), 1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_g4 [11] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h1};
    logic       exp_e4 [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int         exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        int   cnt [N];
        int   tmr [N];
        int   order [$];
        logic pv;

        rst_n = 1'b1;
        req   = '0;
        #1 rst_n = 1'b0;

        // Reset holds everything at zero even with requests pending.
        repeat (2) tick();
        req = 4'b1111;
        tick();
        check("rst_hold_grant", grant, 4'b0000);
        check("rst_hold_valid", grant_valid, 1'b0);
        rst_n = 1'b1;
        tick();
        check("first_grant", grant, 4'b0001);
        check("first_id", grant_id, 2'd0);
        req = '0;
        repeat (3) tick();

        // Single master holds for five cycles, then releases without expire.
        req = 4'b0100;
        tick();
        check("solo_grant", grant, 4'b0100);
        check("solo_id", grant_id, 2'd2);
        repeat (4) tick();
        check("solo_grant_c5", grant, 4'b0100);
        req = '0;
        tick();
        check("solo_release", grant, 4'b0000);
        check("solo_no_expire", expire, 1'b0);
        tick();

        // Four masters, each releasing after three granted cycles.
        do_reset();
        req = 4'b1111;
        pv  = 1'b0;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            tmr[i] = 0;
        end
        for (int c = 0; c < 30; c++) begin
            tick();
            if (grant_valid && !pv) order.push_back(int'(grant_id));
            pv = grant_valid;
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 3) begin
                        req[i] = 1'b0;
                        cnt[i] = 0;
                        tmr[i] = 2;
                    end
                end else if (tmr[i] > 0) begin
                    tmr[i]--;
                    if (tmr[i] == 0) req[i] = 1'b1;
                end
            end
        end
        check("order_len", (order.size() >= 5), 1);
        for (int k = 0; k < 5; k++) begin
            if (k < order.size()) check("order", order[k], exp_order[k]);
        end
        req = '0;
        repeat (3) tick();

        // Tenure limit under contention between masters 0 and 2.
        do_reset();
        req = 4'b0101;
        for (int k = 0; k < 11; k++) begin
            tick();
            check("tenure_grant", grant, exp_g4[k]);
            check("tenure_expire", expire, exp_e4[k]);
        end
        req = '0;
        repeat (2) tick();

        // Sole requester is never preempted.
        req = 4'b0010;
        tick();
        for (int k = 0; k < 20; k++) begin
            check("sole_grant", grant, 4'b0010);
            check("sole_expire", expire, 1'b0);
            tick();
        end

        // Asynchronous reset in the middle of master 1's tenure.
        rst_n = 1'b0;
        #1;
        check("async_grant", grant, 4'b0000);
        check("async_valid", grant_valid, 1'b0);
        check("async_id", grant_id, 2'd0);
        check("async_expire", expire, 1'b0);
        tick();
        req   = 4'b1010;
        rst_n = 1'b1;
        tick();
        check("post_rst_grant", grant, 4'b0010);
        check("post_rst_id", grant_id, 2'd1);
        tick();
        check("post_rst_hold", grant, 4'b0010);
        req = 4'b1000;
        tick();
        check("post_rst_gap", grant, 4'b0000);
        check("post_rst_gap_exp", expire, 1'b0);
        tick();
        check("post_rst_next", grant, 4'b1000);
        check("post_rst_next_id", grant_id, 2'd3);
        req = '0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
